// File: rtl/rv_pkg.sv
// RV32I opcode map, immediate formats and the decoded-entry record shared by
// the decode stage and the opcode decoder.
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [4:0] OPC_LOAD      = 5'b00000;
    localparam logic [4:0] OPC_LOAD_FP   = 5'b00001;
    localparam logic [4:0] OPC_CUSTOM_0  = 5'b00010;
    localparam logic [4:0] OPC_MISC_MEM  = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM    = 5'b00100;
    localparam logic [4:0] OPC_AUIPC     = 5'b00101;
    localparam logic [4:0] OPC_OP_IMM_32 = 5'b00110;
    localparam logic [4:0] OPC_LEN_48    = 5'b00111;
    localparam logic [4:0] OPC_STORE     = 5'b01000;
    localparam logic [4:0] OPC_STORE_FP  = 5'b01001;
    localparam logic [4:0] OPC_CUSTOM_1  = 5'b01010;
    localparam logic [4:0] OPC_AMO       = 5'b01011;
    localparam logic [4:0] OPC_OP        = 5'b01100;
    localparam logic [4:0] OPC_LUI       = 5'b01101;
    localparam logic [4:0] OPC_OP_32     = 5'b01110;
    localparam logic [4:0] OPC_LEN_64    = 5'b01111;
    localparam logic [4:0] OPC_MADD      = 5'b10000;
    localparam logic [4:0] OPC_MSUB      = 5'b10001;
    localparam logic [4:0] OPC_NMSUB     = 5'b10010;
    localparam logic [4:0] OPC_NMADD     = 5'b10011;
    localparam logic [4:0] OPC_OP_FP     = 5'b10100;
    localparam logic [4:0] OPC_RSVD_0    = 5'b10101;
    localparam logic [4:0] OPC_CUSTOM_2  = 5'b10110;
    localparam logic [4:0] OPC_LEN_48B   = 5'b10111;
    localparam logic [4:0] OPC_BRANCH    = 5'b11000;
    localparam logic [4:0] OPC_JALR      = 5'b11001;
    localparam logic [4:0] OPC_RSVD_1    = 5'b11010;
    localparam logic [4:0] OPC_JAL       = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM    = 5'b11100;
    localparam logic [4:0] OPC_RSVD_2    = 5'b11101;
    localparam logic [4:0] OPC_CUSTOM_3  = 5'b11110;
    localparam logic [4:0] OPC_LEN_80    = 5'b11111;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

    typedef struct packed {
        logic [4:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        illegal;
    } decoded_t;

    function automatic logic is_rv32i_opcode(input logic [4:0] opc);
        case (opc)
            OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_STORE,
            OPC_OP, OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM:
                return 1'b1;
            default:
                return 1'b0;
        endcase
    endfunction

    function automatic imm_fmt_e imm_format(input logic [4:0] opc);
        case (opc)
            OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM:
                return IMM_I;
            OPC_STORE:           return IMM_S;
            OPC_BRANCH:          return IMM_B;
            OPC_LUI, OPC_AUIPC:  return IMM_U;
            OPC_JAL:             return IMM_J;
            default:             return IMM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: picks the format from the opcode field and assembles
// the sign-extended 32-bit immediate. The two length bits are not needed here.
module imm_gen
    import rv_pkg::*;
(
    input  logic [31:2] instr,
    output logic [31:0] imm
);

    imm_fmt_e fmt;

    assign fmt = imm_format(instr[6:2]);

    always_comb begin
        imm = '0;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Fetch-to-decoder pipeline stage: slices RV32I words, builds the immediate,
// flags illegal encodings and buffers results in a 2-entry skid buffer.
module instr_decode_stage
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [4:0]      id_opcode,
    output logic [4:0]      id_rd,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    output logic [2:0]      id_funct3,
    output logic [6:0]      id_funct7,
    output logic [XLEN-1:0] id_imm,
    output logic [XLEN-1:0] id_pc,
    output logic            id_illegal
);

    stage_state_e state;
    stage_state_e state_next;
    decoded_t     dec;
    decoded_t     main_q;
    decoded_t     skid_q;
    logic [31:0]  dec_imm;
    logic         in_xfer;
    logic         out_xfer;

    imm_gen u_imm_gen (
        .instr (if_instr[31:2]),
        .imm   (dec_imm)
    );

    always_comb begin
        dec         = '0;
        dec.opcode  = if_instr[6:2];
        dec.rd      = if_instr[11:7];
        dec.rs1     = if_instr[19:15];
        dec.rs2     = if_instr[24:20];
        dec.funct3  = if_instr[14:12];
        dec.funct7  = if_instr[31:25];
        dec.imm     = dec_imm;
        dec.pc      = if_pc;
        dec.illegal = (if_instr[1:0] != 2'b11)
                   || !is_rv32i_opcode(if_instr[6:2])
                   || (if_instr == 32'h0000_0000)
                   || (if_instr == 32'hFFFF_FFFF);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Flush wins over both handshakes; otherwise track the entry count.
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: if (in_xfer) state_next = ONE;
                ONE: begin
                    if (in_xfer && !out_xfer) begin
                        state_next = FULL;
                    end else if (!in_xfer && out_xfer) begin
                        state_next = EMPTY;
                    end
                end
                FULL:    if (out_xfer) state_next = ONE;
                default: state_next = EMPTY;
            endcase
        end
    end

    // Ready depends on state alone so id_ready never reaches if_ready.
    always_comb begin
        if_ready = (state != FULL);
        id_valid = (state != EMPTY);
    end

    assign in_xfer  = if_valid && if_ready;
    assign out_xfer = id_valid && id_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else if (!flush) begin
            case (state)
                EMPTY: begin
                    if (in_xfer) main_q <= dec;
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_q <= dec;
                    end else if (in_xfer) begin
                        skid_q <= dec;
                    end
                end
                FULL: begin
                    if (out_xfer) main_q <= skid_q;
                end
                default: ;
            endcase
        end
    end

    assign id_opcode  = main_q.opcode;
    assign id_rd      = main_q.rd;
    assign id_rs1     = main_q.rs1;
    assign id_rs2     = main_q.rs2;
    assign id_funct3  = main_q.funct3;
    assign id_funct7  = main_q.funct7;
    assign id_imm     = main_q.imm;
    assign id_pc      = main_q.pc;
    assign id_illegal = main_q.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage: an independent decode model
// feeds a FIFO scoreboard that is compared on every output transfer.
module tb_instr_decode_stage;

    typedef struct packed {
        logic [4:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        illegal;
    } dec_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_valid;
    logic        id_ready;
    logic [4:0]  id_opcode;
    logic [4:0]  id_rd;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [2:0]  id_funct3;
    logic [6:0]  id_funct7;
    logic [31:0] id_imm;
    logic [31:0] id_pc;
    logic        id_illegal;

    int   compared   = 0;
    int   mismatched = 0;
    dec_t sb[$];

    instr_decode_stage #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_opcode  (id_opcode),
        .id_rd      (id_rd),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_funct3  (id_funct3),
        .id_funct7  (id_funct7),
        .id_imm     (id_imm),
        .id_pc      (id_pc),
        .id_illegal (id_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic dec_t model(input logic [31:0] w, input logic [31:0] pc);
        dec_t d;
        logic legal;
        d.opcode = w[6:2];
        d.rd     = w[11:7];
        d.rs1    = w[19:15];
        d.rs2    = w[24:20];
        d.funct3 = w[14:12];
        d.funct7 = w[31:25];
        d.pc     = pc;
        case (w[6:2])
            5'b00000, 5'b00011, 5'b00100, 5'b11001, 5'b11100:
                d.imm = {{20{w[31]}}, w[31:20]};
            5'b01000: d.imm = {{20{w[31]}}, w[31:25], w[11:7]};
            5'b11000: d.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            5'b01101, 5'b00101: d.imm = {w[31:12], 12'h000};
            5'b11011: d.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default:  d.imm = 32'h0;
        endcase
        case (w[6:2])
            5'b00000, 5'b00011, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
            5'b01101, 5'b11000, 5'b11001, 5'b11011, 5'b11100: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        d.illegal = (w[1:0] != 2'b11) || !legal || (w == 32'h0) || (w == 32'hFFFF_FFFF);
        return d;
    endfunction

    // One clock of stimulus; records what the DUT shows and keeps the scoreboard in step.
    task automatic step(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                        input logic rdy, input logic fl,
                        output logic fired, output logic accepted,
                        output logic valid_seen, output logic ready_seen,
                        output dec_t got, output dec_t exp);
        @(negedge clk);
        if_valid = v;
        if_instr = instr;
        if_pc    = pc;
        id_ready = rdy;
        flush    = fl;
        #1;
        valid_seen = id_valid;
        ready_seen = if_ready;
        accepted   = v && if_ready;
        fired      = id_valid && rdy && !fl && rst_n;
        got = '{id_opcode, id_rd, id_rs1, id_rs2, id_funct3, id_funct7,
                id_imm, id_pc, id_illegal};
        exp = ~got;
        if (fired && sb.size() > 0) exp = sb.pop_front();
        if (!rst_n || fl) begin
            sb.delete();
        end else if (accepted) begin
            sb.push_back(model(instr, pc));
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
        if_instr = 32'h0; if_pc = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        compared++;
        if (id_valid !== 1'b0) begin
            mismatched++; $display("[TB] FAIL reset_valid: got %b expected 0", id_valid);
        end
        compared++;
        if (if_ready !== 1'b1) begin
            mismatched++; $display("[TB] FAIL reset_ready: got %b expected 1", if_ready);
        end
        compared++;
        if ({id_opcode, id_rd, id_rs1, id_rs2, id_funct3, id_funct7, id_imm, id_pc, id_illegal} !== '0) begin
            mismatched++; $display("[TB] FAIL reset_data: got imm %h pc %h expected 0", id_imm, id_pc);
        end
    endtask

    task automatic test_addi();
        logic f, a, vs, rs;
        dec_t g, e;
        step(1'b1, 32'h0050_0093, 32'h100, 1'b1, 1'b0, f, a, vs, rs, g, e);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, f, a, vs, rs, g, e);
        compared++;
        if (f !== 1'b1) begin
            mismatched++; $display("[TB] FAIL addi_valid: got %b expected 1", f);
        end
        compared++;
        if (g !== e) begin
            mismatched++; $display("[TB] FAIL addi_entry: got %h expected %h", g, e);
        end
        compared++;
        if ({g.opcode, g.rd, g.rs1, g.imm, g.illegal} !== {5'b00100, 5'd1, 5'd0, 32'h5, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL addi_fields: got opc %b rd %0d rs1 %0d imm %h ill %b expected 00100 1 0 00000005 0",
                     g.opcode, g.rd, g.rs1, g.imm, g.illegal);
        end
    endtask

    task automatic test_back_to_back();
        logic f, a, vs, rs;
        dec_t g, e;
        logic [31:0] imms [2];
        imms[0] = 32'h1234_5000;
        imms[1] = 32'hFFFF_FFFC;
        step(1'b1, 32'h1234_5137, 32'h200, 1'b1, 1'b0, f, a, vs, rs, g, e);
        for (int i = 0; i < 2; i++) begin
            if (i == 0) step(1'b1, 32'hFE00_0EE3, 32'h204, 1'b1, 1'b0, f, a, vs, rs, g, e);
            else        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, f, a, vs, rs, g, e);
            compared++;
            if (f !== 1'b1) begin
                mismatched++; $display("[TB] FAIL b2b_nobubble%0d: got %b expected 1", i, f);
            end
            compared++;
            if (g.imm !== imms[i] || g !== e) begin
                mismatched++; $display("[TB] FAIL b2b_entry%0d: got %h expected %h (imm %h)", i, g, e, imms[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic f, a, vs, rs;
        dec_t g, e;
        logic [31:0] pcs [2];
        pcs[0] = 32'h300;
        pcs[1] = 32'h304;
        step(1'b1, 32'h0000_0001, 32'h300, 1'b1, 1'b0, f, a, vs, rs, g, e);
        for (int i = 0; i < 2; i++) begin
            if (i == 0) step(1'b1, 32'h0000_000B, 32'h304, 1'b1, 1'b0, f, a, vs, rs, g, e);
            else        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, f, a, vs, rs, g, e);
            compared++;
            if (f !== 1'b1 || g.illegal !== 1'b1 || g.pc !== pcs[i]) begin
                mismatched++;
                $display("[TB] FAIL illegal%0d: got fired %b ill %b pc %h expected 1 1 %h", i, f, g.illegal, g.pc, pcs[i]);
            end
            compared++;
            if (g !== e) begin
                mismatched++; $display("[TB] FAIL illegal_entry%0d: got %h expected %h", i, g, e);
            end
        end
    endtask

    task automatic test_backpressure();
        logic f, a, vs, rs;
        dec_t g, e;
        logic [31:0] pcs [3];
        logic [31:0] offer;
        int k = 0;
        int n = 0;
        pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8;
        for (int c = 0; c < 20 && n < 3; c++) begin
            offer = (k < 3) ? pcs[k] : 32'h0;
            step(k < 3, 32'h0050_0093, offer, c >= 3, 1'b0, f, a, vs, rs, g, e);
            if (c == 2) begin
                compared++;
                if (rs !== 1'b0 || a !== 1'b0) begin
                    mismatched++; $display("[TB] FAIL bp_full_ready: got %b expected 0", rs);
                end
            end
            if (a) k++;
            if (f) begin
                compared++;
                if (g.pc !== pcs[n] || g !== e) begin
                    mismatched++; $display("[TB] FAIL bp_order%0d: got pc %h expected pc %h", n, g.pc, pcs[n]);
                end
                n++;
            end
        end
        compared++;
        if (n != 3) begin
            mismatched++; $display("[TB] FAIL bp_timeout: got %0d outputs expected 3", n);
        end
    endtask

    task automatic test_flush();
        logic f, a, vs, rs;
        dec_t g, e;
        step(1'b1, 32'h0050_0093, 32'h400, 1'b0, 1'b0, f, a, vs, rs, g, e);
        step(1'b1, 32'h0050_0093, 32'h404, 1'b0, 1'b0, f, a, vs, rs, g, e);
        step(1'b1, 32'h0050_0093, 32'h408, 1'b1, 1'b1, f, a, vs, rs, g, e);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, f, a, vs, rs, g, e);
        compared++;
        if (vs !== 1'b0 || rs !== 1'b1) begin
            mismatched++; $display("[TB] FAIL flush_full: got valid %b ready %b expected 0 1", vs, rs);
        end
        // Flush from ONE with a same-cycle accept: the new word must vanish too.
        step(1'b1, 32'h0050_0093, 32'h500, 1'b0, 1'b0, f, a, vs, rs, g, e);
        step(1'b1, 32'h1234_5137, 32'h504, 1'b1, 1'b1, f, a, vs, rs, g, e);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, f, a, vs, rs, g, e);
            compared++;
            if (f !== 1'b0 || vs !== 1'b0) begin
                mismatched++; $display("[TB] FAIL flush_ghost%0d: got valid %b pc %h expected 0", i, vs, g.pc);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic f, a, vs, rs;
        dec_t g, e;
        step(1'b1, 32'h1234_5137, 32'h600, 1'b0, 1'b0, f, a, vs, rs, g, e);
        rst_n = 1'b0;
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, f, a, vs, rs, g, e);
        rst_n = 1'b1;
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, f, a, vs, rs, g, e);
        compared++;
        if (vs !== 1'b0 || rs !== 1'b1 || g.imm !== 32'h0 || g.pc !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_mid: got valid %b ready %b imm %h pc %h expected 0 1 0 0", vs, rs, g.imm, g.pc);
        end
    endtask

    task automatic test_random();
        logic f, a, vs, rs;
        dec_t g, e;
        logic [31:0] words [14];
        logic [31:0] w;
        int pre;
        int left;
        words = '{32'h0050_0093, 32'h1234_5137, 32'hFE00_0EE3, 32'h0000_0001,
                  32'h0000_000B, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0011_2023,
                  32'h0080_00EF, 32'hFFF0_0067, 32'h0000_0073, 32'h0000_100F,
                  32'h00B5_0533, 32'h8000_1017};
        for (int c = 0; c < 120; c++) begin
            w = ($urandom_range(0, 4) == 0) ? $urandom() : words[$urandom_range(0, 13)];
            pre = sb.size();
            step($urandom_range(0, 3) != 0, w, 32'h1000 + 32'(c * 4),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
                 f, a, vs, rs, g, e);
            compared++;
            if (vs !== (pre > 0) || rs !== (pre < 2)) begin
                mismatched++;
                $display("[TB] FAIL rand_hs%0d: got valid %b ready %b expected %b %b", c, vs, rs, pre > 0, pre < 2);
            end
            if (f) begin
                compared++;
                if (g !== e) begin
                    mismatched++; $display("[TB] FAIL rand_entry%0d: got %h expected %h", c, g, e);
                end
            end
        end
        left = 10;
        while (sb.size() > 0 && left > 0) begin
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, f, a, vs, rs, g, e);
            if (f) begin
                compared++;
                if (g !== e) begin
                    mismatched++; $display("[TB] FAIL drain_entry: got %h expected %h", g, e);
                end
            end
            left--;
        end
        compared++;
        if (sb.size() != 0) begin
            mismatched++; $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_illegal();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
